stage_memory_hs: RTL and testbench

Parametrised successor to the single-cycle memory stage: sits between execute and writeback in the 5-stage pipeline and drives data memory through a request/acknowledge handshake, so variable-latency memories work. It stalls the upstream stages while an access is in flight, applies W→M bypassing to store data, and registers results into the M/W pipeline register with a valid bit. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/stage_memory_hs.sv | 177 +++++++++++++++++
 tb/tb_stage_memory_hs.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the handshaked memory stage: load/store opcodes,
// the access FSM state type and a small opcode decode helper.
package mem_stage_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LW = 5'b01000;
  localparam logic [OP_W-1:0] OP_SW = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // True for the two opcodes that touch data memory.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/stage_memory_hs.sv
// stage_memory_hs: memory stage between execute and writeback, driving data
// memory through a req/ack handshake so variable-latency memories work.
//
// Optional feature macro: MEM_BOUND_CHECK_EN (range-check lw/sw against DEPTH;
// out-of-range accesses complete without a request and raise fault_out).
//
// Ports:
//   clock, resetn          clock and synchronous active-low reset
//   valid_in, insn_in      X/M instruction (opcode = insn_in[31:27])
//   o_in, b_in             ALU result (address) and store data
//   wm_bypass, data_writeReg  W->M bypass select and writeback result
//   stall_out              holds F/D/X and X/M (combinational)
//   dmem_req, wren, address_dmem, d_dmem   registered memory request
//   dmem_ack, q_dmem       memory completion pulse and read data
//   valid_out, insn_out, o_out, d_out, fault_out   M/W pipeline register
module stage_memory_hs
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              valid_in,
  input  logic [31:0]       insn_in,
  input  logic [DATA_W-1:0] o_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              wm_bypass,
  input  logic [DATA_W-1:0] data_writeReg,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              wren,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] d_dmem,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              valid_out,
  output logic [31:0]       insn_out,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] d_out,
  output logic              fault_out
);

`ifdef MEM_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  localparam int unsigned INSN_W = 32;
  // One extra bit so DEPTH == 2^DATA_W would still compare correctly.
  localparam logic [DATA_W:0] DEPTH_W = (DATA_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic                dmem_req_q, dmem_req_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dmem_data_q, dmem_data_d;
  logic [INSN_W-1:0]   req_insn_q, req_insn_d;
  logic [DATA_W-1:0]   req_o_q, req_o_d;
  logic                valid_q, valid_d;
  logic [INSN_W-1:0]   insn_out_q, insn_out_d;
  logic [DATA_W-1:0]   o_out_q, o_out_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                fault_q, fault_d;

  logic mem_op_c;
  logic oob_c;
  logic req_is_lw_c;

  assign mem_op_c    = is_mem_op(insn_in[31:27]);
  assign oob_c       = BOUND_EN && mem_op_c && ({1'b0, o_in} >= DEPTH_W);
  assign req_is_lw_c = (req_insn_q[31:27] == OP_LW);

  // Next-state and stall logic for the access FSM and M/W register.
  always_comb begin
    state_d     = state_q;
    dmem_req_d  = dmem_req_q;
    wren_d      = wren_q;
    addr_d      = addr_q;
    dmem_data_d = dmem_data_q;
    req_insn_d  = req_insn_q;
    req_o_d     = req_o_q;
    valid_d     = valid_q;
    insn_out_d  = insn_out_q;
    o_out_d     = o_out_q;
    d_out_d     = d_out_q;
    fault_d     = fault_q;
    stall_out   = 1'b0;

    case (state_q)
      IDLE: begin
        // A stray ack here belongs to an abandoned access and is ignored.
        if (!valid_in) begin
          valid_d = 1'b0;
        end else if (mem_op_c && !oob_c) begin
          stall_out   = 1'b1;
          state_d     = WAIT;
          dmem_req_d  = 1'b1;
          wren_d      = (insn_in[31:27] == OP_SW);
          addr_d      = o_in[ADDR_W-1:0];
          dmem_data_d = wm_bypass ? data_writeReg : b_in;
          req_insn_d  = insn_in;
          req_o_d     = o_in;
          valid_d     = 1'b0;
        end else begin
          // Non-memory op, or an out-of-range access completing as a fault.
          valid_d    = 1'b1;
          insn_out_d = insn_in;
          o_out_d    = o_in;
          d_out_d    = '0;
          fault_d    = oob_c;
        end
      end
      WAIT: begin
        stall_out = ~dmem_ack;
        valid_d   = 1'b0;
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          wren_d     = 1'b0;
          valid_d    = 1'b1;
          insn_out_d = req_insn_q;
          o_out_d    = req_o_q;
          d_out_d    = req_is_lw_c ? q_dmem : '0;
          fault_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      dmem_req_q  <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      dmem_data_q <= '0;
      req_insn_q  <= '0;
      req_o_q     <= '0;
      valid_q     <= 1'b0;
      insn_out_q  <= '0;
      o_out_q     <= '0;
      d_out_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dmem_req_q  <= dmem_req_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      dmem_data_q <= dmem_data_d;
      req_insn_q  <= req_insn_d;
      req_o_q     <= req_o_d;
      valid_q     <= valid_d;
      insn_out_q  <= insn_out_d;
      o_out_q     <= o_out_d;
      d_out_q     <= d_out_d;
      fault_q     <= fault_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign wren         = wren_q;
  assign address_dmem = addr_q;
  assign d_dmem       = dmem_data_q;
  assign valid_out    = valid_q;
  assign insn_out     = insn_out_q;
  assign o_out        = o_out_q;
  assign d_out        = d_out_q;
  assign fault_out    = fault_q;

endmodule

// File: tb/tb_stage_memory_hs.sv
// Bench for stage_memory_hs: directed table, reset-abandon sequence and a
// randomized instruction stream checked against a per-instruction model.
module tb_stage_memory_hs;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 12;
  localparam int unsigned DEP = 1024;

  localparam logic [4:0] LW   = 5'b01000;
  localparam logic [4:0] SW   = 5'b00111;
  localparam logic [4:0] ADDI = 5'b00101;

  logic          clock;
  logic          resetn;
  logic          valid_in;
  logic [31:0]   insn_in;
  logic [DW-1:0] o_in;
  logic [DW-1:0] b_in;
  logic          wm_bypass;
  logic [DW-1:0] data_writeReg;
  logic          stall_out;
  logic          dmem_req;
  logic          wren;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] d_dmem;
  logic          dmem_ack;
  logic [DW-1:0] q_dmem;
  logic          valid_out;
  logic [31:0]   insn_out;
  logic [DW-1:0] o_out;
  logic [DW-1:0] d_out;
  logic          fault_out;

  int n_cmp;
  int n_bad;

  stage_memory_hs #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clock(clock), .resetn(resetn), .valid_in(valid_in), .insn_in(insn_in),
    .o_in(o_in), .b_in(b_in), .wm_bypass(wm_bypass), .data_writeReg(data_writeReg),
    .stall_out(stall_out), .dmem_req(dmem_req), .wren(wren),
    .address_dmem(address_dmem), .d_dmem(d_dmem), .dmem_ack(dmem_ack),
    .q_dmem(q_dmem), .valid_out(valid_out), .insn_out(insn_out), .o_out(o_out),
    .d_out(d_out), .fault_out(fault_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [4:0]  op;
    logic [26:0] rest;
    logic [31:0] o;
    logic [31:0] b;
    logic        byp;
    logic [31:0] wr;
    int          lat;
    logic [31:0] q;
    logic        e_mem;
    logic        e_wren;
    logic [11:0] e_addr;
    logic [31:0] e_dd;
    logic [31:0] e_d;
    logic        e_fault;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic vld, input logic [4:0] op, input logic [31:0] o,
                               input logic [31:0] b, input logic byp, input logic [31:0] wr,
                               input int lat, input logic [31:0] q);
    vec_t v;
    v.vld = vld; v.op = op; v.rest = 27'h5A5A5A5; v.o = o; v.b = b; v.byp = byp;
    v.wr = wr; v.lat = lat; v.q = q;
    v.e_mem = 1'b0; v.e_wren = 1'b0; v.e_addr = '0; v.e_dd = '0; v.e_d = '0; v.e_fault = 1'b0;
    return v;
  endfunction

  // Reference: what the instruction should do, from the ISA-level rules.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    logic is_mem;
    logic oob;
    v = vi;
    is_mem = v.vld && (v.op == LW || v.op == SW);
`ifdef MEM_BOUND_CHECK_EN
    oob = is_mem && (v.o >= DEP);
`else
    oob = 1'b0;
`endif
    v.e_mem   = is_mem && !oob;
    v.e_wren  = (v.op == SW);
    v.e_addr  = v.o[11:0];
    v.e_dd    = v.byp ? v.wr : v.b;
    v.e_d     = (v.e_mem && v.op == LW) ? v.q : 32'h0;
    v.e_fault = oob;
    return v;
  endfunction

  // Holds one instruction in X/M for as long as the stage should stall, acting
  // as the memory (ack after v.lat request cycles), then checks M/W.
  task automatic run_vec(input vec_t v);
    int dur;
    dur = v.e_mem ? 1 + v.lat : 1;
    for (int c = 1; c <= dur; c++) begin
      valid_in = v.vld;
      insn_in  = {v.op, v.rest};
      o_in     = v.o;
      if (c == 1) begin
        b_in = v.b; wm_bypass = v.byp; data_writeReg = v.wr;
      end else begin
        // Upstream W result moves on; the captured request must not.
        wm_bypass = 1'($urandom_range(0, 1)); data_writeReg = $urandom; b_in = $urandom;
      end
      if (v.e_mem) begin
        dmem_ack = (c == dur);
        q_dmem   = (c == dur) ? v.q : $urandom;
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
        q_dmem   = $urandom;
      end
      #1;
      chk("stall_out", 32'(stall_out), 32'(c < dur));
      if (v.e_mem && c >= 2) begin
        chk("dmem_req", 32'(dmem_req), 32'd1);
        chk("wren", 32'(wren), 32'(v.e_wren));
        chk("address_dmem", 32'(address_dmem), 32'(v.e_addr));
        chk("d_dmem", d_dmem, v.e_dd);
      end else begin
        chk("dmem_req_idle", 32'(dmem_req), 32'd0);
      end
      @(posedge clock); #1;
      if (c < dur) begin
        chk("valid_out_busy", 32'(valid_out), 32'd0);
      end else begin
        chk("valid_out", 32'(valid_out), 32'(v.vld));
        if (v.vld) begin
          chk("insn_out", insn_out, {v.op, v.rest});
          chk("o_out", o_out, v.o);
          chk("d_out", d_out, v.e_d);
          chk("fault_out", 32'(fault_out), 32'(v.e_fault));
        end
      end
    end
    dmem_ack = 1'b0;
  endtask

  vec_t tbl [6];
  vec_t v;

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; valid_in = 1'b0; insn_in = '0; o_in = '0; b_in = '0;
    wm_bypass = 1'b0; data_writeReg = '0; dmem_ack = 1'b0; q_dmem = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_fault_out", 32'(fault_out), 32'd0);
    chk("rst_o_out", o_out, 32'd0);
    chk("rst_d_out", d_out, 32'd0);
    chk("rst_insn_out", insn_out, 32'd0);
    chk("rst_d_dmem", d_dmem, 32'd0);
    chk("rst_address", 32'(address_dmem), 32'd0);
    resetn = 1'b1;

    // Directed table with hand-derived expectations.
    tbl[0] = mkv(1'b1, ADDI, 32'd7, 32'h0, 1'b0, 32'h0, 1, 32'h0);
    tbl[1] = mkv(1'b1, SW, 32'h010, 32'hDEAD, 1'b0, 32'h0, 3, 32'h1111);
    tbl[1].e_mem = 1'b1; tbl[1].e_wren = 1'b1; tbl[1].e_addr = 12'h010; tbl[1].e_dd = 32'hDEAD;
    tbl[2] = mkv(1'b1, LW, 32'h010, 32'h0, 1'b0, 32'h0, 1, 32'hBEEF);
    tbl[2].e_mem = 1'b1; tbl[2].e_addr = 12'h010; tbl[2].e_d = 32'hBEEF;
    tbl[3] = mkv(1'b1, SW, 32'h020, 32'h5555, 1'b1, 32'h1234, 2, 32'h0);
    tbl[3].e_mem = 1'b1; tbl[3].e_wren = 1'b1; tbl[3].e_addr = 12'h020; tbl[3].e_dd = 32'h1234;
    tbl[4] = mkv(1'b0, LW, 32'h030, 32'h0, 1'b0, 32'h0, 1, 32'h0);
    tbl[5] = mkv(1'b1, LW, 32'h3FF, 32'h9, 1'b1, 32'h77, 4, 32'hCAFEF00D);
    tbl[5].e_mem = 1'b1; tbl[5].e_addr = 12'h3FF; tbl[5].e_dd = 32'h77; tbl[5].e_d = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

`ifdef MEM_BOUND_CHECK_EN
    // Out-of-range load faults without a request; next instruction clears it.
    v = mkv(1'b1, LW, 32'd1024, 32'h0, 1'b0, 32'h0, 1, 32'h0);
    v.e_fault = 1'b1;
    run_vec(v);
    run_vec(mkv(1'b1, ADDI, 32'd3, 32'h0, 1'b0, 32'h0, 1, 32'h0));
`else
    // Address is truncated to the word-address width.
    v = mkv(1'b1, LW, 32'h0000_5010, 32'h0, 1'b0, 32'h0, 2, 32'h600D);
    v.e_mem = 1'b1; v.e_addr = 12'h010; v.e_d = 32'h600D;
    run_vec(v);
`endif

    // Reset during WAIT abandons the access; the late ack is ignored.
    valid_in = 1'b1; insn_in = {LW, 27'h0}; o_in = 32'h44; dmem_ack = 1'b0;
    @(posedge clock); #1;
    valid_in = 1'b0; resetn = 1'b0;
    @(posedge clock); #1;
    chk("rstwait_dmem_req", 32'(dmem_req), 32'd0);
    chk("rstwait_valid_out", 32'(valid_out), 32'd0);
    resetn = 1'b1; dmem_ack = 1'b1; q_dmem = 32'hBAD;
    #1;
    chk("late_ack_stall", 32'(stall_out), 32'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    chk("late_ack_valid_out", 32'(valid_out), 32'd0);
    chk("late_ack_dmem_req", 32'(dmem_req), 32'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [31:0] o;
      case ($urandom_range(0, 4))
        0, 1:    op = LW;
        2:       op = SW;
        3:       op = ADDI;
        default: op = 5'($urandom);
      endcase
      o = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      v = mkv(1'($urandom_range(0, 7) != 0), op, o, $urandom, 1'($urandom_range(0, 1)),
              $urandom, int'($urandom_range(1, 4)), $urandom);
      v.rest = 27'($urandom);
      run_vec(model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
